apb_gpio_regs: RTL

GPIO register bank sitting directly downstream of the APB slave handshake FSM: consumes PREADY and commits APB reads/writes at the completion cycle. Holds output data, direction, and interrupt configuration, synchronises the GPIO input pins, detects edges, and drives a level interrupt. All state is in the PCLK domain except the raw pins.

---
 rtl/apb_gpio_regs_if.sv | 22 ++
 rtl/apb_gpio_regs.sv | 115 +++++++++++
 2 files changed

// File: rtl/apb_gpio_regs_if.sv
// APB slave-side bus bundle for the GPIO register bank.
// PREADY is driven by the upstream handshake FSM, so it sits on the master side.
interface apb_gpio_regs_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY,
    input  PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY,
    output PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_regs.sv
// GPIO register bank: output/direction registers, synchronised inputs with
// per-bit edge detection, W1C interrupt status and a registered level irq.
module apb_gpio_regs #(
  parameter int WIDTH = 32
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_gpio_regs_if.slave   apb,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] ADDR_DIR        = 3'd1;
  localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
  localparam logic [2:0] ADDR_IRQ_POL    = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;

  logic [WIDTH-1:0] data_out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] irq_en_reg;
  logic [WIDTH-1:0] irq_pol_reg;
  logic [WIDTH-1:0] irq_status_reg;
  logic [WIDTH-1:0] irq_status_next;
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] prev_reg;
  logic             irq_reg;

  logic [2:0]       reg_sel;
  logic             xfer;
  logic             addr_err;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_val;

  // Address low bits and any data bits above WIDTH are intentionally ignored.
  logic unused_apb;
  assign unused_apb = ^{apb.PADDR[1:0], apb.PWDATA};

  assign reg_sel  = apb.PADDR[4:2];
  assign xfer     = apb.PSEL & apb.PENABLE & apb.PREADY;
  assign addr_err = (reg_sel == 3'd6) | (reg_sel == 3'd7) |
                    (apb.PWRITE & (reg_sel == ADDR_DATA_IN));
  assign wr_en    = xfer & apb.PWRITE & ~addr_err;
  assign wdata    = apb.PWDATA[WIDTH-1:0];

  // Per-pin edge select: rising when polarity is 1, falling otherwise.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign hit[gi] = irq_pol_reg[gi] ? (sync2_reg[gi] & ~prev_reg[gi])
                                       : (~sync2_reg[gi] & prev_reg[gi]);
    end
  endgenerate

  // A fresh edge wins over a simultaneous write-one-to-clear on the same bit.
  assign clr             = (wr_en && reg_sel == ADDR_IRQ_STATUS) ? wdata : '0;
  assign irq_status_next = (irq_status_reg & ~clr) | hit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      data_out_reg   <= '0;
      dir_reg        <= '0;
      irq_en_reg     <= '0;
      irq_pol_reg    <= '0;
      irq_status_reg <= '0;
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      prev_reg       <= '0;
      irq_reg        <= 1'b0;
    end else begin
      sync1_reg      <= gpio_in;
      sync2_reg      <= sync1_reg;
      prev_reg       <= sync2_reg;
      irq_status_reg <= irq_status_next;
      irq_reg        <= |(irq_status_reg & irq_en_reg);
      if (wr_en) begin
        case (reg_sel)
          ADDR_DATA_OUT: data_out_reg <= wdata;
          ADDR_DIR:      dir_reg      <= wdata;
          ADDR_IRQ_EN:   irq_en_reg   <= wdata;
          ADDR_IRQ_POL:  irq_pol_reg  <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      ADDR_DATA_OUT:   rd_val = data_out_reg;
      ADDR_DIR:        rd_val = dir_reg;
      ADDR_DATA_IN:    rd_val = sync2_reg;
      ADDR_IRQ_EN:     rd_val = irq_en_reg;
      ADDR_IRQ_POL:    rd_val = irq_pol_reg;
      ADDR_IRQ_STATUS: rd_val = irq_status_reg;
      default:         rd_val = '0;
    endcase
  end

  assign apb.PRDATA  = (apb.PSEL && !apb.PWRITE) ? 32'(rd_val) : 32'd0;
  assign apb.PSLVERR = xfer & addr_err;

  assign gpio_out = data_out_reg;
  assign gpio_oe  = dir_reg;
  assign irq      = irq_reg;

endmodule
